// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM states, line levels,
// parity selection constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  // Even parity makes the total count of ones even; odd parity makes it odd.
  function automatic logic parity_of(input logic [7:0] data, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator working on the byte latched at frame
// acceptance, so later changes on the parallel input cannot disturb it.
module uart_tx_parity_calc
  import uart_pkg::*;
(
  input  logic [7:0] data,
  input  logic       par_typ,
  output logic       par_bit
);

  assign par_bit = parity_of(data, par_typ);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one 8-bit word per request, start bit, data LSB first,
// optional parity, stop bit, one bit per clock. TX_OUT and busy are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic       Data_Valid,
  input  logic [7:0] P_data,
  output logic       TX_OUT,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] data_reg;
  logic [7:0] shift_reg;
  logic       par_en_reg;
  logic       par_typ_reg;
  logic       par_reg;
  logic       par_calc;
  logic       tx_next;
  logic       accept;

  // A request is only honoured while idle; anything else is dropped.
  assign accept = (state == IDLE) && Data_Valid;

  uart_tx_parity_calc u_parity (
    .data    (data_reg),
    .par_typ (par_typ_reg),
    .par_bit (par_calc)
  );

  // Output mux: the level the line takes at the next edge for the current state.
  always_comb begin
    tx_next = STOP_BIT;
    case (state)
      START:   tx_next = START_BIT;
      DATA:    tx_next = shift_reg[0];
      PARITY:  tx_next = par_reg;
      STOP:    tx_next = STOP_BIT;
      default: tx_next = STOP_BIT;
    endcase
  end

  // Frame sequencing, bit counter and registered line/busy outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      TX_OUT  <= STOP_BIT;
      busy    <= 1'b0;
    end else begin
      TX_OUT <= tx_next;
      case (state)
        IDLE: begin
          busy    <= 1'b0;
          bit_cnt <= 3'd0;
          if (accept) begin
            state <= START;
          end
        end
        START: begin
          busy  <= 1'b1;
          state <= DATA;
        end
        DATA: begin
          busy    <= 1'b1;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) begin
            state <= par_en_reg ? PARITY : STOP;
          end
        end
        PARITY: begin
          busy  <= 1'b1;
          state <= STOP;
        end
        STOP: begin
          // The stop bit goes out now; busy falls when the line returns to idle.
          busy  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Serializer and frame-setting latches, captured once at acceptance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_reg    <= 8'd0;
      shift_reg   <= 8'd0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= PAR_EVEN;
      par_reg     <= 1'b0;
    end else begin
      if (accept) begin
        data_reg    <= P_data;
        shift_reg   <= P_data;
        par_en_reg  <= PAR_EN;
        par_typ_reg <= PAR_TYP;
      end else if (state == START) begin
        // Parity is settled from the latched byte before the data bits start.
        par_reg <= par_calc;
      end else if (state == DATA) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus randomized traffic
// against a queue-based model of the serial line.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       Data_Valid;
  logic [7:0] P_data;
  logic       TX_OUT;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  logic [31:0] hist = '0;
  string phase = "init";

  // Bits the line must show on the coming cycles; empty means idle.
  bit exp_q[$];

  uart_tx dut (
    .CLK        (CLK),
    .RST        (RST),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Data_Valid (Data_Valid),
    .P_data     (P_data),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s.%s got %0h expected %0h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  function automatic void load_frame(input logic [7:0] d, input logic pe, input logic pt);
    int ones;
    ones = $countones(d);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
    exp_q.push_back(1'b1);
  endfunction

  // One clock: drive inputs, update the model at the edge, compare at the falling edge.
  task automatic cycle(input logic dv, input logic [7:0] d, input logic pe, input logic pt);
    logic etx, ebusy;
    Data_Valid = dv;
    P_data     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    @(posedge CLK);
    if (exp_q.size() > 0) begin
      etx   = exp_q.pop_front();
      ebusy = 1'b1;
    end else begin
      etx   = 1'b1;
      ebusy = 1'b0;
      if (dv) load_frame(d, pe, pt);
    end
    @(negedge CLK);
    check("tx", {31'd0, TX_OUT}, {31'd0, etx});
    check("busy", {31'd0, busy}, {31'd0, ebusy});
    hist = {hist[30:0], TX_OUT};
    if (busy) busy_cnt++;
  endtask

  // Accept one frame, then run its full length with scrambled inputs.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt, input logic noise_dv);
    int len;
    len = pe ? 11 : 10;
    cycle(1'b1, d, pe, pt);
    for (int i = 0; i < len; i++)
      cycle(noise_dv && (i == 3), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Asynchronous reset in the middle of a low clock phase; entered and left at a falling edge.
  task automatic async_reset();
    Data_Valid = 1'b0;
    #2 RST = 1'b1;
    #1;
    check("rst_tx_async", {31'd0, TX_OUT}, 32'd1);
    check("rst_busy_async", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(negedge CLK);
    check("rst_tx_hold", {31'd0, TX_OUT}, 32'd1);
    check("rst_busy_hold", {31'd0, busy}, 32'd0);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    Data_Valid = 1'b0;
    P_data = 8'h00;
    #1;
    check("reset_tx", {31'd0, TX_OUT}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    phase = "t1";
    run_frame(8'b10111010, 1'b1, 1'b0, 1'b0);
    check("frame", {21'd0, hist[10:0]}, {21'd0, 11'b00101110111});
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    phase = "t2";
    busy_cnt = 0;
    run_frame(8'b10111011, 1'b0, 1'b0, 1'b0);
    check("frame", {22'd0, hist[9:0]}, {22'd0, 10'b0110111011});
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("idle_tx", {31'd0, TX_OUT}, 32'd1);
    check("busy_len", busy_cnt, 10);

    phase = "t3";
    run_frame(8'b10111011, 1'b1, 1'b0, 1'b0);
    check("par_even6", {31'd0, hist[1]}, 32'd0);
    run_frame(8'b10011011, 1'b1, 1'b0, 1'b0);
    check("par_even5", {31'd0, hist[1]}, 32'd1);

    phase = "t4";
    run_frame(8'b10011011, 1'b1, 1'b1, 1'b0);
    check("par_odd5", {31'd0, hist[1]}, 32'd0);
    run_frame(8'b10010011, 1'b1, 1'b1, 1'b0);
    check("par_odd4", {31'd0, hist[1]}, 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    phase = "t5";
    busy_cnt = 0;
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    run_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    check("b2b_frame", {21'd0, hist[10:0]}, {21'd0, 11'b00011110011});
    check("b2b_busy", busy_cnt, 21);
    busy_cnt = 0;
    run_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("pulse_busy", busy_cnt, 10);

    phase = "t6";
    cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    async_reset();
    run_frame(8'h00, 1'b0, 1'b0, 1'b0);
    check("after_rst", {22'd0, hist[9:0]}, {22'd0, 10'b0000000001});

    phase = "hold";
    busy_cnt = 0;
    for (int i = 0; i < 25; i++) cycle(1'b1, 8'h81, 1'b0, 1'b0);
    Data_Valid = 1'b0;
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("hold_busy", busy_cnt, 30);

    phase = "rand";
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      else cycle($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
